// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Read data returned to a requester whose transaction hit the watchdog.
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the port that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_port
);

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_port  = PORT_I;
        if (req_i && req_d) begin
            gnt_port = ~last_grant;
        end else if (req_d) begin
            gnt_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports, one
// outstanding transaction at a time, with round-robin fairness and a watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t    state, state_nxt;
    logic          last_grant, last_grant_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          m_req_nxt;
    logic          m_we_nxt;
    logic [AW-1:0] m_addr_nxt;
    logic [DW-1:0] m_wdata_nxt;
    logic          i_ack_nxt;
    logic          d_ack_nxt;
    logic [DW-1:0] i_rdata_nxt;
    logic [DW-1:0] d_rdata_nxt;
    logic          err_nxt;

    logic          gnt_valid;
    logic          gnt_port;
    logic          timeout_hit;
    logic          txn_done;
    logic [DW-1:0] resp_data;

    // A port that is being acked this cycle sits out one cycle to present its next address.
    rr_arb2 u_rr (
        .req_i      (i_req & ~i_ack),
        .req_d      (d_req & ~d_ack),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign txn_done    = m_ack | timeout_hit;
    assign resp_data   = m_ack ? m_rdata : DW'(ABORT_DATA);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        m_req_nxt      = m_req;
        m_we_nxt       = m_we;
        m_addr_nxt     = m_addr;
        m_wdata_nxt    = m_wdata;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        err_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    last_grant_nxt = gnt_port;
                    cnt_nxt        = '0;
                    m_req_nxt      = 1'b1;
                    if (gnt_port == PORT_D) begin
                        state_nxt   = BUSY_D;
                        m_we_nxt    = d_we;
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                    end else begin
                        state_nxt   = BUSY_I;
                        m_we_nxt    = 1'b0;
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = '0;
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                if (txn_done) begin
                    // m_ack takes priority over a simultaneous timeout.
                    state_nxt = IDLE;
                    m_req_nxt = 1'b0;
                    err_nxt   = ~m_ack;
                    if (state == BUSY_D) begin
                        if (d_req) begin
                            d_ack_nxt   = 1'b1;
                            d_rdata_nxt = resp_data;
                        end
                    end else if (i_req) begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = resp_data;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                m_req_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_D;
            cnt        <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            m_req      <= m_req_nxt;
            m_we       <= m_we_nxt;
            m_addr     <= m_addr_nxt;
            m_wdata    <= m_wdata_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .err     (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: one outstanding transaction, age = m_req cycles elapsed.
    bit          mdl_busy;
    bit          mdl_port;
    bit          mdl_last;
    int          mdl_age;
    logic        e_mreq, e_mwe, e_iack, e_dack, e_err;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;

    // Memory behaviour: ack when age reaches lat.
    int          lat = 0;
    bit          rand_lat = 0;
    bit          idle_noise = 0;
    bit          rdata_fixed = 0;
    logic [31:0] rdata_val = '0;

    task automatic model_reset();
        mdl_busy = 0; mdl_port = 0; mdl_last = 1; mdl_age = 0;
        e_mreq = 0; e_mwe = 0; e_iack = 0; e_dack = 0; e_err = 0;
        e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
    endtask

    task automatic model_step();
        bit   want, ei, ed, pick_d;
        logic ni, nd, ne;
        int   r;
        ni = 0; nd = 0; ne = 0;
        if (mdl_busy) begin
            mdl_age++;
            want = mdl_port ? d_req : i_req;
            if (m_ack || mdl_age == TO) begin
                mdl_busy = 0;
                ne = !m_ack;
                if (want) begin
                    if (mdl_port) begin nd = 1; e_drdata = m_ack ? m_rdata : 32'hDEADBEEF; end
                    else          begin ni = 1; e_irdata = m_ack ? m_rdata : 32'hDEADBEEF; end
                end
            end
        end else begin
            ei = i_req && !e_iack;
            ed = d_req && !e_dack;
            if (ei || ed) begin
                pick_d   = (ei && ed) ? !mdl_last : ed;
                mdl_busy = 1; mdl_port = pick_d; mdl_last = pick_d; mdl_age = 0;
                e_maddr  = pick_d ? d_addr : i_addr;
                e_mwe    = pick_d ? d_we : 1'b0;
                e_mwdata = pick_d ? d_wdata : 32'h0;
                if (rand_lat) begin
                    r = int'($urandom_range(0, 9));
                    if (r <= 5)      lat = r % 4;
                    else if (r <= 7) lat = TO - 1;
                    else if (r == 8) lat = NEVER;
                    else             lat = TO - 2;
                end
            end
        end
        e_iack = ni; e_dack = nd; e_err = ne; e_mreq = mdl_busy;
    endtask

    task automatic check_outputs();
        check("m_req",   32'(m_req),   32'(e_mreq));
        check("m_we",    32'(m_we),    32'(e_mwe));
        check("m_addr",  m_addr,       e_maddr);
        check("m_wdata", m_wdata,      e_mwdata);
        check("i_ack",   32'(i_ack),   32'(e_iack));
        check("d_ack",   32'(d_ack),   32'(e_dack));
        check("i_rdata", i_rdata,      e_irdata);
        check("d_rdata", d_rdata,      e_drdata);
        check("err",     32'(err),     32'(e_err));
    endtask

    task automatic drive_mem();
        if (mdl_busy) m_ack = (mdl_age == lat);
        else          m_ack = idle_noise ? ($urandom_range(0, 5) == 0) : 1'b0;
        m_rdata = rdata_fixed ? rdata_val : $urandom();
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        rand_lat = 0; idle_noise = 0; rdata_fixed = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 0;
    endtask

    logic        mr [16];
    logic        ia [16];
    logic [31:0] ird [16];

    initial begin
        int mcnt, ack_idx, rise_idx, ng, ecnt;
        bit saw, prev;
        logic ack_v;
        logic [31:0] rd_v;

        #1 reset = 1;
        do_reset();

        // Fetch only, three-cycle memory.
        lat = 2; rdata_fixed = 1; rdata_val = 32'h8C010004;
        i_req = 1; i_addr = 32'h100;
        for (int c = 0; c < 12; c++) begin
            drive_mem(); cycle();
            mr[c] = m_req; ia[c] = i_ack; ird[c] = i_rdata;
        end
        mcnt = 0; ack_idx = -1; rise_idx = -1;
        for (int c = 0; c < 12; c++) begin
            if (ack_idx < 0 && mr[c]) mcnt++;
            if (ack_idx < 0 && ia[c]) ack_idx = c;
            if (ack_idx >= 0 && c > ack_idx && rise_idx < 0 && mr[c]) rise_idx = c;
        end
        check("fetch_mreq_cycles", 32'(mcnt), 32'd3);
        check("fetch_ack_cycle", 32'(ack_idx), 32'd3);
        check("fetch_rdata", (ack_idx >= 0) ? ird[ack_idx] : 32'hX, 32'h8C010004);
        check("fetch_gap", 32'(rise_idx >= ack_idx + 1 && rise_idx >= 4), 32'd1);

        // Contention, zero-wait memory: I, D, I, D.
        do_reset();
        lat = 0; rdata_fixed = 0;
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55;
        ng = 0; prev = 0;
        for (int c = 0; c < 16; c++) begin
            drive_mem(); cycle();
            if (m_req && !prev) begin
                check("cont_addr",  m_addr,      (ng % 2 == 0) ? 32'h100 : 32'h2000);
                check("cont_we",    32'(m_we),   (ng % 2 == 0) ? 32'd0 : 32'd1);
                check("cont_wdata", m_wdata,     (ng % 2 == 0) ? 32'h0 : 32'h55);
                ng++;
            end
            prev = m_req;
        end
        check("cont_grants", 32'(ng), 32'd8);

        // Withdrawal of a fetch before m_ack.
        do_reset();
        lat = 3; d_req = 0; i_req = 1; i_addr = 32'h300;
        drive_mem(); cycle();
        drive_mem(); cycle();
        i_req = 0;
        ecnt = 0;
        for (int c = 0; c < 6; c++) begin
            drive_mem(); cycle();
            if (i_ack) ecnt++;
        end
        check("wd_no_ack", 32'(ecnt), 32'd0);
        check("wd_rdata", i_rdata, 32'h0);
        check("wd_idle", 32'(m_req), 32'd0);
        d_req = 1; d_we = 0; d_addr = 32'h700;
        drive_mem(); cycle();
        check("wd_regrant_req", 32'(m_req), 32'd1);
        check("wd_regrant_addr", m_addr, 32'h700);

        // Timeout on a data read.
        do_reset();
        lat = NEVER; i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h40;
        mcnt = 0; saw = 0; ack_v = 0; rd_v = '0;
        for (int c = 0; c < 20; c++) begin
            drive_mem(); cycle();
            if (m_req) mcnt++;
            if (err) begin saw = 1; ack_v = d_ack; rd_v = d_rdata; d_req = 0; break; end
        end
        check("to_mreq_cycles", 32'(mcnt), 32'd8);
        check("to_err", 32'(saw), 32'd1);
        check("to_dack", 32'(ack_v), 32'd1);
        check("to_rdata", rd_v, 32'hDEADBEEF);

        // m_ack on the last watchdog cycle wins over the abort.
        do_reset();
        lat = TO - 1; rdata_fixed = 1; rdata_val = 32'h12345678;
        d_req = 1; d_addr = 32'h44;
        mcnt = 0; saw = 0; ecnt = 0;
        for (int c = 0; c < 20; c++) begin
            drive_mem(); cycle();
            if (m_req) mcnt++;
            if (err) ecnt++;
            if (d_ack) begin saw = 1; rd_v = d_rdata; d_req = 0; break; end
        end
        drive_mem(); cycle();
        if (err) ecnt++;
        check("edge_mreq_cycles", 32'(mcnt), 32'd8);
        check("edge_ack", 32'(saw), 32'd1);
        check("edge_no_err", 32'(ecnt), 32'd0);
        check("edge_rdata", rd_v, 32'h12345678);

        // Asynchronous reset in the middle of a data transaction.
        do_reset();
        lat = NEVER; rdata_fixed = 0; d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h9;
        for (int c = 0; c < 3; c++) begin drive_mem(); cycle(); end
        check("pre_rst_mreq", 32'(m_req), 32'd1);
        #2 reset = 1;
        #1;
        check("async_rst_mreq", 32'(m_req), 32'd0);
        check("async_rst_dack", 32'(d_ack), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        do_reset();
        lat = 0; i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h2000;
        drive_mem(); cycle();
        check("post_rst_tie_req", 32'(m_req), 32'd1);
        check("post_rst_tie_addr", m_addr, 32'h100);

        // Randomized traffic against the model.
        do_reset();
        rand_lat = 1; idle_noise = 1; lat = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_req) i_req = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 9) == 0) i_req = 0;
            if (!d_req) d_req = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 9) == 0) d_req = 0;
            if ($urandom_range(0, 1) == 1) i_addr = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                d_addr  = $urandom();
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom();
            end
            drive_mem(); cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
